// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit single-cycle core: opcodes, fetch FSM
// states and the branch/jump target table.
package core_pkg;

    localparam int PC_W_DEF = 8;

    localparam logic [3:0] LB_OP   = 4'b0000;
    localparam logic [3:0] SB_OP   = 4'b0001;
    localparam logic [3:0] ADD_OP  = 4'b0010;
    localparam logic [3:0] SUB_OP  = 4'b0011;
    localparam logic [3:0] AND_OP  = 4'b0100;
    localparam logic [3:0] OR_OP   = 4'b0101;
    localparam logic [3:0] XOR_OP  = 4'b0110;
    localparam logic [3:0] SHL_OP  = 4'b0111;
    localparam logic [3:0] SHR_OP  = 4'b1000;
    localparam logic [3:0] LI_OP   = 4'b1001;
    localparam logic [3:0] JMP_OP  = 4'b1010;
    localparam logic [3:0] BEQ_OP  = 4'b1011;
    localparam logic [3:0] BNE_OP  = 4'b1100;
    localparam logic [3:0] BLT_OP  = 4'b1101;
    localparam logic [3:0] HALT_OP = 4'b1110;
    localparam logic [3:0] TBA_OP  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2
    } fetch_state_t;

    // Branch/jump destinations selected by the 3-bit immediate.
    localparam logic [PC_W_DEF-1:0] JUMP_TARGETS [0:7] = '{
        8'h08, 8'h18, 8'h30, 8'h40, 8'h55, 8'h80, 8'hC0, 8'hFE
    };

endpackage

// File: rtl/jump_lut.sv
// Combinational lookup of a branch/jump target from the 3-bit immediate.
module jump_lut
    import core_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [2:0]      idx,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] table_w [0:7];

    // Resize each packaged target to the program-counter width.
    for (genvar gi = 0; gi < 8; gi++) begin : g_entry
        assign table_w[gi] = PC_W'(JUMP_TARGETS[gi]);
    end

    assign target = table_w[idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter, instruction split and IDLE/RUN/HALTED control for the
// single-cycle core. The ROM is read asynchronously at pc_o.
module fetch_unit
    import core_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic [8:0]       instr_i,
    input  logic             flag_eq,
    input  logic             flag_lt,
    output logic [PC_W-1:0]  pc_o,
    output logic [3:0]       opcode,
    output logic [2:0]       imm_o,
    output logic [1:0]       rsel_o,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] icount
);

    fetch_state_t     state_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] icount_reg;
    logic [CNT_W-1:0] icount_next;
    logic             running_reg;
    logic             done_reg;
    logic [3:0]       op_w;
    logic             taken;

    assign op_w = instr_i[8:5];

    jump_lut #(.PC_W(PC_W)) u_jump_lut (
        .idx    (instr_i[2:0]),
        .target (target)
    );

    // Branch resolution: taken branches go to the table target, all else pc+1.
    always_comb begin
        taken = 1'b0;
        case (op_w)
            JMP_OP:  taken = 1'b1;
            BEQ_OP:  taken = flag_eq;
            BNE_OP:  taken = !flag_eq;
            BLT_OP:  taken = flag_lt;
            default: taken = 1'b0;
        endcase
        pc_next     = taken ? target : pc_reg + PC_W'(1);
        icount_next = (&icount_reg) ? icount_reg : icount_reg + CNT_W'(1);
    end

    // Control FSM; start overrides whatever the current instruction would do.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            icount_reg  <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else if (start) begin
            state_reg   <= ST_RUN;
            pc_reg      <= start_addr;
            icount_reg  <= '0;
            running_reg <= 1'b1;
            done_reg    <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            icount_reg <= icount_next;
            if (op_w == HALT_OP) begin
                state_reg   <= ST_HALTED;
                running_reg <= 1'b0;
                done_reg    <= 1'b1;
            end else begin
                pc_reg <= pc_next;
            end
        end
    end

    assign pc_o    = pc_reg;
    assign icount  = icount_reg;
    assign running = running_reg;
    assign done    = done_reg;
    assign opcode  = running_reg ? op_w         : HALT_OP;
    assign imm_o   = running_reg ? instr_i[2:0] : 3'b000;
    assign rsel_o  = running_reg ? instr_i[4:3] : 2'b00;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model plus directed and
// randomized stimulus.
module tb_fetch_unit;

    localparam logic [3:0] T_ADD  = 4'b0010;
    localparam logic [3:0] T_JMP  = 4'b1010;
    localparam logic [3:0] T_BEQ  = 4'b1011;
    localparam logic [3:0] T_BNE  = 4'b1100;
    localparam logic [3:0] T_BLT  = 4'b1101;
    localparam logic [3:0] T_HALT = 4'b1110;
    localparam logic [3:0] T_TBA  = 4'b1111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  instr_i;
    logic        flag_eq;
    logic        flag_lt;
    logic [7:0]  pc_o;
    logic [3:0]  opcode;
    logic [2:0]  imm_o;
    logic [1:0]  rsel_o;
    logic        running;
    logic        done;
    logic [15:0] icount;

    logic [8:0]  rom [0:255];
    logic [7:0]  tgt [0:7] = '{8'h08, 8'h18, 8'h30, 8'h40, 8'h55, 8'h80, 8'hC0, 8'hFE};

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: mode 0 idle, 1 run, 2 halted.
    int          m_mode = 0;
    logic [7:0]  m_pc   = 8'h00;
    int unsigned m_cnt  = 0;

    always #5 clk = ~clk;

    assign instr_i = rom[pc_o];

    fetch_unit #(.PC_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .instr_i    (instr_i),
        .flag_eq    (flag_eq),
        .flag_lt    (flag_lt),
        .pc_o       (pc_o),
        .opcode     (opcode),
        .imm_o      (imm_o),
        .rsel_o     (rsel_o),
        .running    (running),
        .done       (done),
        .icount     (icount)
    );

    function automatic logic [8:0] enc(input logic [3:0] op, input logic [1:0] rs, input logic [2:0] im);
        return {op, rs, im};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: advance one clock from the spec's rules.
    always @(posedge clk) begin
        logic [8:0] ins;
        logic [3:0] op;
        bit         tk;
        if (reset) begin
            m_mode = 0; m_pc = 8'h00; m_cnt = 0;
        end else if (start) begin
            m_mode = 1; m_pc = start_addr; m_cnt = 0;
        end else if (m_mode == 1) begin
            ins = rom[m_pc];
            op  = ins[8:5];
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (op == T_HALT) begin
                m_mode = 2;
            end else begin
                tk = (op == T_JMP) || (op == T_BEQ && flag_eq) ||
                     (op == T_BNE && !flag_eq) || (op == T_BLT && flag_lt);
                m_pc = tk ? tgt[ins[2:0]] : m_pc + 8'd1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(posedge clk) begin
        logic [8:0] ins;
        #1;
        if (chk_en) begin
            ins = rom[m_pc];
            check("pc_o",    32'(pc_o),    32'(m_pc));
            check("running", 32'(running), 32'(m_mode == 1));
            check("done",    32'(done),    32'(m_mode == 2));
            check("icount",  32'(icount),  m_cnt);
            check("opcode",  32'(opcode),  32'((m_mode == 1) ? ins[8:5] : T_HALT));
            check("imm_o",   32'(imm_o),   32'((m_mode == 1) ? ins[2:0] : 3'b000));
            check("rsel_o",  32'(rsel_o),  32'((m_mode == 1) ? ins[4:3] : 2'b00));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic run_branch(input string name, input logic [7:0] addr, input logic [8:0] ins,
                              input bit eq, input bit lt, input logic [7:0] exp_pc);
        rom[addr] = ins;
        start_addr = addr; start = 1'b1;
        tick;
        start = 1'b0; flag_eq = eq; flag_lt = lt;
        check({name, "_at"}, 32'(pc_o), 32'(addr));
        tick;
        check(name, 32'(pc_o), 32'(exp_pc));
        flag_eq = 1'b0; flag_lt = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = 8'h00; flag_eq = 1'b0; flag_lt = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = enc(T_ADD, 2'b01, 3'b010);
        tick; tick;
        chk_en = 1'b1;
        check("rst_pc", 32'(pc_o), 32'h0);
        check("rst_opcode", 32'(opcode), 32'hE);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick;
            check("idle_pc", 32'(pc_o), 32'h0);
            check("idle_opcode", 32'(opcode), 32'hE);
            check("idle_running", 32'(running), 32'h0);
            check("idle_done", 32'(done), 32'h0);
            check("idle_icount", 32'(icount), 32'h0);
        end

        // ADD, ADD, HALT from 0x10
        rom[8'h10] = enc(T_ADD, 2'b00, 3'b000);
        rom[8'h11] = enc(T_ADD, 2'b00, 3'b000);
        rom[8'h12] = enc(T_HALT, 2'b00, 3'b000);
        start_addr = 8'h10; start = 1'b1;
        tick; start = 1'b0;
        check("seq_pc0", 32'(pc_o), 32'h10);
        check("seq_run0", 32'(running), 32'h1);
        tick; check("seq_pc1", 32'(pc_o), 32'h11);
        tick; check("seq_pc2", 32'(pc_o), 32'h12);
        tick;
        check("seq_pc3", 32'(pc_o), 32'h12);
        check("seq_done", 32'(done), 32'h1);
        check("seq_running", 32'(running), 32'h0);
        check("seq_icount", 32'(icount), 32'h3);

        // Branches through the target table
        run_branch("beq_taken",  8'h20, enc(T_BEQ, 2'b00, 3'd3), 1'b1, 1'b0, 8'h40);
        run_branch("beq_not",    8'h20, enc(T_BEQ, 2'b00, 3'd3), 1'b0, 1'b0, 8'h21);
        run_branch("blt_taken",  8'h30, enc(T_BLT, 2'b10, 3'd3), 1'b0, 1'b1, 8'h40);
        run_branch("blt_not",    8'h30, enc(T_BLT, 2'b10, 3'd3), 1'b1, 1'b0, 8'h31);
        run_branch("bne_not",    8'h50, enc(T_BNE, 2'b00, 3'd3), 1'b1, 1'b0, 8'h51);
        run_branch("bne_taken",  8'h50, enc(T_BNE, 2'b00, 3'd6), 1'b0, 1'b0, 8'hC0);
        run_branch("jmp",        8'h60, enc(T_JMP, 2'b11, 3'd5), 1'b0, 1'b0, 8'h80);
        run_branch("tba_nop",    8'h61, enc(T_TBA, 2'b00, 3'd5), 1'b1, 1'b1, 8'h62);
        rom[8'h20] = enc(T_ADD, 2'b00, 3'b000);

        // PC wrap
        start_addr = 8'hFE; start = 1'b1;
        tick; start = 1'b0;
        check("wrap_fe", 32'(pc_o), 32'hFE);
        tick; check("wrap_ff", 32'(pc_o), 32'hFF);
        tick; check("wrap_00", 32'(pc_o), 32'h00);
        check("wrap_icount", 32'(icount), 32'h2);

        // Start on the HALT cycle
        rom[8'h70] = enc(T_HALT, 2'b00, 3'b000);
        start_addr = 8'h70; start = 1'b1;
        tick;
        check("hs_pc", 32'(pc_o), 32'h70);
        check("hs_opcode", 32'(opcode), 32'hE);
        start_addr = 8'h05;
        tick; start = 1'b0;
        check("hs_pc_next", 32'(pc_o), 32'h05);
        check("hs_running", 32'(running), 32'h1);
        check("hs_done", 32'(done), 32'h0);
        check("hs_icount", 32'(icount), 32'h0);

        // Reset mid-run at 0x22
        start_addr = 8'h20; start = 1'b1;
        tick; start = 1'b0;
        tick; tick;
        check("mr_pc", 32'(pc_o), 32'h22);
        reset = 1'b1;
        tick;
        check("mr_rst_pc", 32'(pc_o), 32'h0);
        check("mr_rst_running", 32'(running), 32'h0);
        check("mr_rst_done", 32'(done), 32'h0);
        check("mr_rst_icount", 32'(icount), 32'h0);
        check("mr_rst_opcode", 32'(opcode), 32'hE);
        check("mr_rst_imm", 32'(imm_o), 32'h0);
        reset = 1'b0;

        // Randomized program and control
        for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 511));
        for (int n = 0; n < 3000; n++) begin
            start      = ($urandom_range(0, 29) == 0) || (done && ($urandom_range(0, 2) == 0));
            reset      = ($urandom_range(0, 299) == 0);
            start_addr = 8'($urandom_range(0, 255));
            flag_eq    = 1'($urandom_range(0, 1));
            flag_lt    = 1'($urandom_range(0, 1));
            tick;
        end
        start = 1'b0; reset = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
